// File: rtl/counter_sequencer.sv
// Job sequencer for an external load/enable/up-down counter: runs a configurable number of
// passes from a start value to an end value, with pause and abort control.
module counter_sequencer #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned REPS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  cfg_start,
    input  logic [WIDTH-1:0]  cfg_end,
    input  logic              cfg_up,
    input  logic [REPS_W-1:0] cfg_reps,
    input  logic              pause,
    input  logic              abort,
    input  logic [WIDTH-1:0]  ctr_count,
    output logic              ctr_load,
    output logic [WIDTH-1:0]  ctr_load_in,
    output logic              ctr_enable,
    output logic              ctr_up,
    output logic              busy,
    output logic              done,
    output logic [REPS_W-1:0] pass_cnt
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  start_q, start_d;
    logic [WIDTH-1:0]  end_q, end_d;
    logic              up_q, up_d;
    logic [REPS_W-1:0] reps_q, reps_d;
    logic [REPS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic              at_end;

    assign at_end   = (ctr_count == end_q);
    assign pass_cnt = pass_cnt_q;

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        end_d       = end_q;
        up_d        = up_q;
        reps_d      = reps_q;
        pass_cnt_d  = pass_cnt_q;
        ctr_load    = 1'b0;
        ctr_load_in = '0;
        ctr_enable  = 1'b0;
        ctr_up      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    start_d    = cfg_start;
                    end_d      = cfg_end;
                    up_d       = cfg_up;
                    reps_d     = (cfg_reps == '0) ? REPS_W'(1) : cfg_reps;
                    pass_cnt_d = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                busy        = 1'b1;
                ctr_load    = 1'b1;
                ctr_load_in = start_q;
                ctr_up      = up_q;
                state_d     = abort ? StIdle : StRun;
            end
            StRun: begin
                busy       = 1'b1;
                ctr_up     = up_q;
                ctr_enable = !pause && !at_end;
                if (abort) begin
                    state_d = StIdle;
                end else if (at_end) begin
                    pass_cnt_d = pass_cnt_q + REPS_W'(1);
                    state_d    = (pass_cnt_d < reps_q) ? StLoad : StDone;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are forced quiet for the whole reset cycle, not just after the edge.
        if (reset) begin
            ctr_load    = 1'b0;
            ctr_load_in = '0;
            ctr_enable  = 1'b0;
            ctr_up      = 1'b0;
            busy        = 1'b0;
            done        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            start_q    <= '0;
            end_q      <= '0;
            up_q       <= 1'b0;
            reps_q     <= '0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            end_q      <= end_d;
            up_q       <= up_d;
            reps_q     <= reps_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: models the controlled counter and checks load values,
// enable sequence and done timing/pass count against hand-derived expectations.
module tb_counter_sequencer;
    localparam int W = 4;
    localparam int R = 4;

    logic         clk = 1'b0;
    logic         reset, start, cfg_up, pause, abort;
    logic [W-1:0] cfg_start, cfg_end;
    logic [R-1:0] cfg_reps;
    logic [W-1:0] ctr_count = '0;
    logic         ctr_load, ctr_enable, ctr_up, busy, done;
    logic [W-1:0] ctr_load_in;
    logic [R-1:0] pass_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int q_load[$];
    int q_en[$];
    int q_done_pass[$];
    int q_done_cyc[$];

    counter_sequencer #(.WIDTH(W), .REPS_W(R)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_start(cfg_start), .cfg_end(cfg_end),
        .cfg_up(cfg_up), .cfg_reps(cfg_reps), .pause(pause), .abort(abort),
        .ctr_count(ctr_count), .ctr_load(ctr_load), .ctr_load_in(ctr_load_in),
        .ctr_enable(ctr_enable), .ctr_up(ctr_up), .busy(busy), .done(done), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    // Controlled counter: load beats enable, wraps modulo 2^W.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ctr_load) ctr_count <= ctr_load_in;
        else if (ctr_enable) ctr_count <= ctr_up ? ctr_count + 1'b1 : ctr_count - 1'b1;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a load, an enable or a done.
    always @(negedge clk) begin
        if (ctr_load) begin
            if (q_load.size() == 0) check("unexpected_load", 1, 0);
            else check("load_up_val_en", {ctr_enable, ctr_up, ctr_load_in}, q_load.pop_front());
        end
        if (ctr_enable) begin
            if (q_en.size() == 0) check("unexpected_enable", 1, 0);
            else check("enable_count", ctr_count, q_en.pop_front());
        end
        if (done) begin
            if (q_done_pass.size() == 0) check("unexpected_done", 1, 0);
            else begin
                check("done_pass_cnt", pass_cnt, q_done_pass.pop_front());
                check("done_cycle", cyc, q_done_cyc.pop_front());
            end
        end
        if (!busy) check("idle_outputs_quiet",
                         {ctr_load, ctr_enable, ctr_up, done, ctr_load_in}, 0);
    end

    task automatic push_en(input logic [W-1:0] s, input logic up, input int n);
        logic [W-1:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            q_en.push_back(int'(v));
            v = up ? v + 1'b1 : v - 1'b1;
        end
    endtask

    // Called just after a rising edge; pushes expectations and pulses start for one cycle.
    task automatic issue(input logic [W-1:0] s, input logic [W-1:0] e, input logic up,
                         input logic [R-1:0] reps, input int pauses, input bit full);
        int eff;
        int n;
        logic [W-1:0] d;
        eff = (reps == 0) ? 1 : int'(reps);
        d = up ? e - s : s - e;
        n = int'(d);
        for (int p = 0; p < (full ? eff : 1); p++) q_load.push_back({1'b0, up, s});
        if (full) begin
            for (int p = 0; p < eff; p++) push_en(s, up, n);
            q_done_pass.push_back(eff);
            q_done_cyc.push_back(cyc + 1 + eff * (n + 2) + pauses);
        end
        cfg_start = s; cfg_end = e; cfg_up = up; cfg_reps = reps; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_start = '0; cfg_end = '0; cfg_up = 1'b0; cfg_reps = '0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        check({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_count(input logic [W-1:0] v, input string name);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (ctr_count == v) return;
        end
        check({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
        cfg_start = '0; cfg_end = '0; cfg_up = 1'b0; cfg_reps = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, ctr_load, ctr_enable, ctr_up, ctr_load_in}, 0);
        check("reset_pass_cnt", pass_cnt, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic up pass 3 -> 6.
        issue(4'd3, 4'd6, 1'b1, 4'd1, 0, 1'b1);
        wait_idle("up_pass");
        repeat (4) @(posedge clk);
        #1;
        check("pass_cnt_held_idle", pass_cnt, 1);

        // Down pass with wrap, two reps; a mid-job start with other config must be ignored.
        issue(4'd2, 4'd14, 1'b0, 4'd2, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        cfg_start = 4'd7; cfg_end = 4'd7; cfg_up = 1'b1; cfg_reps = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cfg_start = '0; cfg_end = '0; cfg_up = 1'b0; cfg_reps = '0;
        wait_idle("down_wrap");
        check("down_wrap_pass_cnt", pass_cnt, 2);

        // Degenerate pass, reps=0 treated as 1.
        issue(4'd9, 4'd9, 1'b1, 4'd0, 0, 1'b1);
        wait_idle("degenerate");

        // Pause for 3 cycles while count holds at 2.
        issue(4'd0, 4'd4, 1'b1, 4'd1, 3, 1'b1);
        wait_count(4'd2, "pause_wait");
        pause = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pause = 1'b0;
        check("pause_held_count", ctr_count, 2);
        wait_idle("pause");

        // Abort mid-RUN at count 5, then a wrapping up restart with three passes.
        issue(4'd1, 4'd10, 1'b1, 4'd1, 0, 1'b0);
        push_en(4'd1, 1'b1, 5);
        wait_count(4'd5, "abort_wait");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_pass_cnt", pass_cnt, 0);
        issue(4'd12, 4'd1, 1'b1, 4'd3, 0, 1'b1);
        wait_idle("restart");
        check("restart_pass_cnt", pass_cnt, 3);

        // Reset during RUN.
        issue(4'd0, 4'd15, 1'b1, 4'd2, 0, 1'b0);
        push_en(4'd0, 1'b1, 3);
        wait_count(4'd3, "reset_wait");
        reset = 1'b1;
        #4;
        check("midjob_reset_outputs", {busy, done, ctr_load, ctr_enable, ctr_up, ctr_load_in}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("midjob_reset_pass_cnt", pass_cnt, 0);
        check("midjob_reset_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;

        check("leftover_loads", q_load.size(), 0);
        check("leftover_enables", q_en.size(), 0);
        check("leftover_dones", q_done_pass.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
